uart_recv: RTL and testbench

//  Serial receiver paired with the trans transmitter: 8N1 frames on RxD, LSB first, idle high.
//  16x oversampling, 3-sample majority vote per bit, start-bit validation, framing and overrun detection.

---
 rtl/uart_recv.sv | 128 ++++++++++++
 tb/tb_uart_recv.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// 8N1 serial receiver: 16x oversampling, 3-sample majority per bit, start-bit
// validation, framing/overrun pulses, byte delivered under a valid/ack handshake.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | validating the start bit
// DATA  | sampling the eight data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | stop bit was low; waiting for the line to return high
module uart_recv #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud         = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_valid,
    input  logic       RxD_ack,
    output logic       RxD_frame_err,
    output logic       RxD_overrun,
    output logic       RxD_busy
);
    localparam int DivRaw = ClkFrequency / (Baud * 16);
    localparam int Div    = (DivRaw < 1) ? 1 : DivRaw;
    localparam int DivW   = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} stateType;

    stateType        state, stateNext;
    logic            rxMeta, rxs;
    logic [DivW-1:0] divCnt;
    logic [3:0]      osCnt, osNext;
    logic [2:0]      bitCnt;
    logic [7:0]      shiftReg;
    logic            sampA, sampB;
    logic            tick, sampleA, sampleB, decide, bitEnd, majority;
    logic            stopOk, stopBad;

    // Sample points are named by the count reached on the tick, so the
    // decision tick lands 9 ticks into each bit.
    assign tick     = (state != IDLE) && (divCnt == DivLast);
    assign osNext   = osCnt + 4'd1;
    assign sampleA  = tick && (osNext == 4'd7);
    assign sampleB  = tick && (osNext == 4'd8);
    assign decide   = tick && (osNext == 4'd9);
    assign bitEnd   = tick && (osCnt == 4'd15);
    assign majority = (sampA & sampB) | (sampA & rxs) | (sampB & rxs);
    assign stopOk   = (state == STOP) && decide && majority;
    assign stopBad  = (state == STOP) && decide && !majority;
    assign RxD_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:  if (!rxs) stateNext = START;
            START: begin
                if (decide && majority) stateNext = IDLE;
                else if (bitEnd)        stateNext = DATA;
            end
            DATA:  if (bitEnd && bitCnt == 3'd7) stateNext = STOP;
            STOP:  if (decide) stateNext = majority ? IDLE : BREAK;
            BREAK: if (rxs) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rxMeta   <= 1'b1;
            rxs      <= 1'b1;
            divCnt   <= '0;
            osCnt    <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
            sampA    <= 1'b0;
            sampB    <= 1'b0;
        end else begin
            rxMeta <= RxD;
            rxs    <= rxMeta;
            if (state == IDLE) begin
                divCnt <= '0;
                osCnt  <= '0;
            end else if (tick) begin
                divCnt <= '0;
                osCnt  <= osNext;
            end else begin
                divCnt <= divCnt + 1'b1;
            end
            if (state == IDLE || bitEnd) begin
                sampA <= 1'b0;
                sampB <= 1'b0;
            end else begin
                if (sampleA) sampA <= rxs;
                if (sampleB) sampB <= rxs;
            end
            if (state == START && bitEnd)     bitCnt <= '0;
            else if (state == DATA && bitEnd) bitCnt <= bitCnt + 3'd1;
            if (state == DATA && decide) shiftReg[bitCnt] <= majority;
        end
    end

    // A byte completing on the same edge as an ack replaces the old one cleanly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            RxD_data      <= '0;
            RxD_valid     <= 1'b0;
            RxD_frame_err <= 1'b0;
            RxD_overrun   <= 1'b0;
        end else begin
            RxD_frame_err <= stopBad;
            RxD_overrun   <= 1'b0;
            if (stopOk) begin
                RxD_data    <= shiftReg;
                RxD_valid   <= 1'b1;
                RxD_overrun <= RxD_valid & ~RxD_ack;
            end else if (RxD_valid && RxD_ack) begin
                RxD_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_recv.sv
// Directed bench for uart_recv at DIV=1 (16 clocks per bit); inputs driven on
// the falling edge, outputs checked on the falling edge.
module tb_uart_recv;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       RxD = 1'b1;
    logic       RxD_ack = 1'b0;
    logic [7:0] RxD_data;
    logic       RxD_valid;
    logic       RxD_frame_err;
    logic       RxD_overrun;
    logic       RxD_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int startCyc = 0;
    int ferrCnt = 0;
    int ovrCnt = 0;
    int waitCnt;

    uart_recv #(.ClkFrequency(1600000), .Baud(100000)) dut (
        .clk(clk), .rst(rst), .RxD(RxD),
        .RxD_data(RxD_data), .RxD_valid(RxD_valid), .RxD_ack(RxD_ack),
        .RxD_frame_err(RxD_frame_err), .RxD_overrun(RxD_overrun), .RxD_busy(RxD_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (RxD_frame_err) ferrCnt++;
        if (RxD_overrun)   ovrCnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 160 one-clock slots: start, 8 data bits LSB first, stop; one slot may be inverted.
    task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int glitchSlot);
        logic val;
        for (int s = 0; s < 160; s++) begin
            @(negedge clk);
            if (s == 0) startCyc = cyc;
            if (s < 16)       val = 1'b0;
            else if (s < 144) val = b[s/16 - 1];
            else              val = stopBit;
            if (s == glitchSlot) val = ~val;
            RxD = val;
        end
    endtask

    task automatic idleLine(input int n);
        @(negedge clk);
        RxD = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic ackByte();
        @(negedge clk);
        RxD_ack = 1'b1;
        @(negedge clk);
        RxD_ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", RxD_data, 8'h00);
        check("rst_valid", RxD_valid, 1'b0);
        check("rst_busy", RxD_busy, 1'b0);
        check("rst_ferr", RxD_frame_err, 1'b0);
        check("rst_ovr", RxD_overrun, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 0xA5, latency from line fall to valid, ack two clocks later
        fork
            sendFrame(8'hA5, 1'b1, -1);
            begin
                waitCnt = 0;
                @(negedge clk);
                while (!RxD_valid && waitCnt < 400) begin
                    @(negedge clk);
                    waitCnt++;
                end
                check("t1_valid_rise", RxD_valid, 1'b1);
                check("t1_latency", cyc - startCyc, 156);
                check("t1_data", RxD_data, 8'hA5);
                repeat (2) @(negedge clk);
                check("t1_valid_at_ack", RxD_valid, 1'b1);
                RxD_ack = 1'b1;
                @(negedge clk);
                RxD_ack = 1'b0;
                check("t1_valid_clear", RxD_valid, 1'b0);
            end
        join
        idleLine(10);
        check("t1_ferr_cnt", ferrCnt, 0);
        check("t1_ovr_cnt", ovrCnt, 0);

        // 2: 5-clock low pulse rejected as a glitch
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            RxD = 1'b0;
        end
        @(negedge clk);
        RxD = 1'b1;
        check("t2_busy_start", RxD_busy, 1'b1);
        repeat (20) @(negedge clk);
        check("t2_busy_idle", RxD_busy, 1'b0);
        check("t2_valid", RxD_valid, 1'b0);
        check("t2_ferr_cnt", ferrCnt, 0);
        check("t2_data", RxD_data, 8'hA5);

        // 3: 0x3C with low stop bit, line held low, then released
        sendFrame(8'h3C, 1'b0, -1);
        repeat (20) @(negedge clk);
        check("t3_ferr_cnt", ferrCnt, 1);
        check("t3_break_busy", RxD_busy, 1'b1);
        check("t3_data", RxD_data, 8'hA5);
        check("t3_valid", RxD_valid, 1'b0);
        idleLine(5);
        check("t3_idle", RxD_busy, 1'b0);

        // 4: back-to-back 0x11, 0x22 without ack
        sendFrame(8'h11, 1'b1, -1);
        check("t4_first", RxD_data, 8'h11);
        sendFrame(8'h22, 1'b1, -1);
        idleLine(5);
        check("t4_ovr_cnt", ovrCnt, 1);
        check("t4_data", RxD_data, 8'h22);
        check("t4_valid", RxD_valid, 1'b1);
        ackByte();
        check("t4_valid_clear", RxD_valid, 1'b0);

        // 5: 0x00 with a one-clock high glitch on the middle sample of bit 3
        sendFrame(8'h00, 1'b1, 72);
        idleLine(5);
        check("t5_data", RxD_data, 8'h00);
        check("t5_valid", RxD_valid, 1'b1);
        ackByte();

        // 6: reset during data bit 4, then a clean 0x5A
        fork
            sendFrame(8'hC3, 1'b1, -1);
            begin
                repeat (88) @(negedge clk);
                check("t6_busy_mid", RxD_busy, 1'b1);
                rst = 1'b0;
            end
        join
        idleLine(4);
        check("t6_rst_data", RxD_data, 8'h00);
        check("t6_rst_valid", RxD_valid, 1'b0);
        check("t6_rst_busy", RxD_busy, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        sendFrame(8'h5A, 1'b1, -1);
        idleLine(5);
        check("t6_data", RxD_data, 8'h5A);
        check("t6_valid", RxD_valid, 1'b1);
        check("t6_ferr_cnt", ferrCnt, 1);
        check("t6_ovr_cnt", ovrCnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
